// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_SRC
// writeback sources; one registered write per cycle, x0 targets are dropped.
module regs_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic                      wr_hold,
  output logic [REG_AW-1:0]         rd,
  output logic [XLEN-1:0]           rd_wr_data,
  output logic                      rd_wr_en,
  output logic                      x0_drop
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  sel;
  logic              grant;
  logic [REG_AW-1:0] rd_arr   [NUM_SRC];
  logic [XLEN-1:0]   data_arr [NUM_SRC];
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign rd_arr[gi]   = src_rd[gi*REG_AW +: REG_AW];
      assign data_arr[gi] = src_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Scan ptr, ptr+1, ... (wrapping); the first valid source wins.
  always_comb begin
    grant     = 1'b0;
    sel       = '0;
    src_ready = '0;
    ptr_next  = ptr_reg;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant && src_valid[(int'(ptr_reg) + i) % NUM_SRC]) begin
        grant = 1'b1;
        sel   = PTR_W'((int'(ptr_reg) + i) % NUM_SRC);
      end
    end
    if (rst || wr_hold) begin
      grant = 1'b0;
    end
    if (grant) begin
      src_ready[sel] = 1'b1;
      ptr_next       = (int'(sel) == NUM_SRC - 1) ? '0 : sel + 1'b1;
    end
  end

  assign sel_rd   = rd_arr[sel];
  assign sel_data = data_arr[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg    <= '0;
      rd         <= '0;
      rd_wr_data <= '0;
      rd_wr_en   <= 1'b0;
      x0_drop    <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      if (grant) begin
        // rd/data are loaded even for x0 so the port reflects the last grant.
        rd         <= sel_rd;
        rd_wr_data <= sel_data;
        rd_wr_en   <= (sel_rd != '0);
        x0_drop    <= (sel_rd == '0);
      end else begin
        rd_wr_en <= 1'b0;
        x0_drop  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: a round-robin reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_regs_wb_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_rd;
  logic [N*XL-1:0] src_data;
  logic            wr_hold;
  logic [AW-1:0]   rd;
  logic [XL-1:0]   rd_wr_data;
  logic            rd_wr_en;
  logic            x0_drop;

  regs_wb_arbiter #(.NUM_SRC(N), .XLEN(XL), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .wr_hold(wr_hold),
    .rd(rd), .rd_wr_data(rd_wr_data), .rd_wr_en(rd_wr_en), .x0_drop(x0_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Mock register file fed by the write port.
  logic [XL-1:0] regs_mem [32] = '{default: '0};
  always @(posedge clk) if (rd_wr_en) regs_mem[rd] <= rd_wr_data;

  // Reference model: pointer plus expected port contents.
  int            m_ptr = 0;
  logic [AW-1:0] m_rd = '0;
  logic [XL-1:0] m_data = '0;
  logic          m_en = 1'b0;
  logic          m_drop = 1'b0;

  function automatic int pick();
    if (rst || wr_hold) return -1;
    for (int i = 0; i < N; i++)
      if (src_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_rd <= '0; m_data <= '0; m_en <= 1'b0; m_drop <= 1'b0;
    end else begin
      automatic int k = pick();
      if (k >= 0) begin
        m_rd   <= src_rd[k*AW +: AW];
        m_data <= src_data[k*XL +: XL];
        m_en   <= (src_rd[k*AW +: AW] != 0);
        m_drop <= (src_rd[k*AW +: AW] == 0);
        m_ptr  <= (k + 1) % N;
      end else begin
        m_en   <= 1'b0;
        m_drop <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    automatic int k = pick();
    automatic logic [N-1:0] exp_ready = (k >= 0) ? (N'(1) << k) : '0;
    chk("model_ready", src_ready, exp_ready);
    chk("model_en", rd_wr_en, m_en);
    chk("model_drop", x0_drop, m_drop);
    chk("model_rd", rd, m_rd);
    chk("model_data", rd_wr_data, m_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [AW-1:0] r, input logic [XL-1:0] d);
    src_rd[k*AW +: AW]   = r;
    src_data[k*XL +: XL] = d;
  endtask

  logic [N-1:0] rr_tbl [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [AW-1:0] rd_tbl [3] = '{5'd1, 5'd2, 5'd3};

  initial begin
    rst = 1'b1; wr_hold = 1'b0; src_valid = '1; src_rd = '0; src_data = '0;
    set_src(0, 5'd1, 32'h11); set_src(1, 5'd2, 32'h22); set_src(2, 5'd3, 32'h33);
    // 1: reset with everybody requesting
    repeat (5) begin
      step();
      chk("rst_ready", src_ready, 3'b000);
      chk("rst_en", rd_wr_en, 1'b0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_data", rd_wr_data, 32'h0);
      chk("rst_drop", x0_drop, 1'b0);
    end
    rst = 1'b0;
    #1 chk("first_grant", src_ready, 3'b001);
    step();
    chk("first_rd", rd, 5'd1);
    chk("first_data", rd_wr_data, 32'h11);
    // 2: single source 1 writing x5
    src_valid = 3'b010; set_src(1, 5'd5, 32'hDEADBEEF);
    #1 chk("s1_ready", src_ready, 3'b010);
    step();
    chk("s1_en", rd_wr_en, 1'b1);
    chk("s1_rd", rd, 5'd5);
    chk("s1_data", rd_wr_data, 32'hDEADBEEF);
    src_valid = '0;
    step();
    chk("s1_regread", regs_mem[5], 32'hDEADBEEF);
    chk("s1_en_off", rd_wr_en, 1'b0);
    // 3: all valid, ptr is 2 -> grants 2,0,1,2,0,1
    set_src(1, 5'd2, 32'h22); src_valid = '1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", src_ready, rr_tbl[i]);
      step();
      chk("rr_en", rd_wr_en, 1'b1);
      chk("rr_rd", rd, rd_tbl[(i + 2) % 3]);
    end
    src_valid = '0;
    step();
    // 4: write to x0 from source 2
    src_valid = 3'b100; set_src(2, 5'd0, 32'hFFFFFFFF);
    #1 chk("x0_ready", src_ready, 3'b100);
    step();
    chk("x0_en", rd_wr_en, 1'b0);
    chk("x0_drop_on", x0_drop, 1'b1);
    src_valid = '0;
    step();
    chk("x0_drop_off", x0_drop, 1'b0);
    chk("x0_regread", regs_mem[0], 32'h0);
    // 5: hold with sources 0 and 2 pending, ptr=1
    src_valid = 3'b001; set_src(0, 5'd7, 32'h77); set_src(2, 5'd9, 32'h99);
    step();
    src_valid = 3'b101; wr_hold = 1'b1;
    #1 chk("hold_ready", src_ready, 3'b000);
    chk("hold_inflight_en", rd_wr_en, 1'b1);
    chk("hold_inflight_rd", rd, 5'd7);
    repeat (4) begin
      step();
      chk("hold_ready_q", src_ready, 3'b000);
      chk("hold_en", rd_wr_en, 1'b0);
    end
    wr_hold = 1'b0;
    #1 chk("resume_first", src_ready, 3'b100);
    step();
    chk("resume_rd", rd, 5'd9);
    chk("resume_second", src_ready, 3'b001);
    step();
    chk("resume_rd2", rd, 5'd7);
    // 6: asynchronous reset pulse mid-cycle under traffic
    src_valid = '1; set_src(0, 5'd1, 32'h11); set_src(2, 5'd3, 32'h33);
    step();
    step();
    #1 rst = 1'b1;
    #1 chk("arst_en", rd_wr_en, 1'b0);
    chk("arst_rd", rd, 5'd0);
    chk("arst_ready", src_ready, 3'b000);
    rst = 1'b0;
    #1 chk("arst_regrant", src_ready, 3'b001);
    step();
    chk("arst_rd_after", rd, 5'd1);
    src_valid = '0;
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
